hc595_receiver: RTL and testbench



---
 rtl/hc595_receiver.sv | 130 +++++++++++++
 tb/tb_hc595_receiver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hc595_receiver.sv
// hc595_receiver: receive-side model of a cascaded 74HC595 chain.
// Rebuilds the latched parallel word from oversampled sclk/rclk/s_data.
module hc595_receiver #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             rclk,
  input  logic             s_data,
  output logic [WIDTH-1:0] p_data,
  output logic             p_valid,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FRM = CNT_W'(WIDTH);

  logic sclk_s1_q, sclk_s1_d;
  logic sclk_s2_q, sclk_s2_d;
  logic sclk_prev_q, sclk_prev_d;
  logic rclk_s1_q, rclk_s1_d;
  logic rclk_s2_q, rclk_s2_d;
  logic rclk_prev_q, rclk_prev_d;
  logic sdat_s1_q, sdat_s1_d;
  logic sdat_s2_q, sdat_s2_d;
  logic [1:0] settle_q, settle_d;
  logic armed;
  logic sclk_rise_q, sclk_rise_d;
  logic rclk_rise_q, rclk_rise_d;
  logic sdat_q, sdat_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] p_data_q, p_data_d;
  logic p_valid_q, p_valid_d;
  logic frame_err_q, frame_err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Sync, edge detect, shift and latch next-state logic.
  always_comb begin
    sclk_s1_d   = sclk;
    sclk_s2_d   = sclk_s1_q;
    sclk_prev_d = sclk_s2_q;
    rclk_s1_d   = rclk;
    rclk_s2_d   = rclk_s1_q;
    rclk_prev_d = rclk_s2_q;
    sdat_s1_d   = s_data;
    sdat_s2_d   = sdat_s1_q;
    // Edges are ignored until the history flop has tracked the
    // synchronised level once, so a stale high level at reset
    // release is not mistaken for a rising edge.
    armed       = (settle_q == 2'd3);
    settle_d    = armed ? settle_q : 2'(settle_q + 2'd1);
    sclk_rise_d = armed & sclk_s2_q & ~sclk_prev_q;
    rclk_rise_d = armed & rclk_s2_q & ~rclk_prev_q;
    sdat_d      = sdat_s2_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    p_data_d    = p_data_q;
    p_valid_d   = 1'b0;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    if (sclk_rise_q) begin
      shreg_d = {shreg_q[WIDTH-2:0], sdat_q};
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CNT_ONE;
      end
    end
    // Latch sees the pre-shift register and pre-increment count.
    if (rclk_rise_q) begin
      p_data_d    = shreg_q;
      p_valid_d   = 1'b1;
      frame_err_d = (bit_cnt_q != CNT_FRM);
      frame_cnt_d = frame_cnt_q + 16'd1;
      bit_cnt_d   = sclk_rise_q ? CNT_ONE : '0;
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      rclk_s1_q   <= 1'b0;
      rclk_s2_q   <= 1'b0;
      rclk_prev_q <= 1'b0;
      sdat_s1_q   <= 1'b0;
      sdat_s2_q   <= 1'b0;
      settle_q    <= 2'd0;
      sclk_rise_q <= 1'b0;
      rclk_rise_q <= 1'b0;
      sdat_q      <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      p_data_q    <= '0;
      p_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      sclk_s1_q   <= sclk_s1_d;
      sclk_s2_q   <= sclk_s2_d;
      sclk_prev_q <= sclk_prev_d;
      rclk_s1_q   <= rclk_s1_d;
      rclk_s2_q   <= rclk_s2_d;
      rclk_prev_q <= rclk_prev_d;
      sdat_s1_q   <= sdat_s1_d;
      sdat_s2_q   <= sdat_s2_d;
      settle_q    <= settle_d;
      sclk_rise_q <= sclk_rise_d;
      rclk_rise_q <= rclk_rise_d;
      sdat_q      <= sdat_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      p_data_q    <= p_data_d;
      p_valid_q   <= p_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign p_data    = p_data_q;
  assign p_valid   = p_valid_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_hc595_receiver.sv
// tb_hc595_receiver: directed frame vectors plus
// tied-clock, reset and wrap sequences.
module tb_hc595_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic        s_data = 1'b0;
  logic [15:0] p_data;
  logic        p_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  hc595_receiver #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .rclk(rclk),
    .s_data(s_data),
    .p_data(p_data),
    .p_valid(p_valid),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] data;
    int          nbits;
    logic [15:0] exp_p;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1);
    rst_n = 1'b0;
    cyc(3);
    check("rst_p_data", int'(p_data), 0);
    check("rst_p_valid", int'(p_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    rst_n = 1'b1;
    cyc(6);
  endtask

  task automatic send_bit(input logic b);
    s_data = b;
    cyc(2);
    sclk = 1'b1;
    cyc(4);
    sclk = 1'b0;
    cyc(4);
  endtask

  task automatic send_bits(input logic [15:0] d, input int n);
    logic [15:0] dv;
    dv = d;
    for (int i = n - 1; i >= 0; i--) begin
      send_bit((i < 16) ? dv[i] : 1'b0);
    end
  endtask

  // rclk pulse of 4 high / 4 low; p_valid must be high only
  // after the 4th edge (T+3, with T the edge that samples rclk=1).
  task automatic latch(input string tag);
    int pulses;
    int at_k;
    pulses = 0;
    at_k = 0;
    rclk = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      if (p_valid) begin
        pulses++;
        at_k = k;
      end
      if (k == 4) rclk = 1'b0;
    end
    check({tag, "_pvalid_cnt"}, pulses, 1);
    check({tag, "_pvalid_lat"}, at_k, 4);
  endtask

  initial begin
    int pv;
    logic last_err;
    logic [15:0] prev_p;

    vecs[0] = '{1'b1, 16'hA5C3, 16, 16'hA5C3, 1'b0, 16'd1};
    vecs[1] = '{1'b1, 16'h7FFF, 15, 16'h7FFF, 1'b1, 16'd1};
    vecs[2] = '{1'b0, 16'h0001, 16, 16'h0001, 1'b0, 16'd2};
    vecs[3] = '{1'b0, 16'h5A69, 300, 16'h5A69, 1'b1, 16'd3};
    vecs[4] = '{1'b0, 16'hC0DE, 16, 16'hC0DE, 1'b0, 16'd4};
    vecs[5] = '{1'b0, 16'h8001, 17, 16'h8001, 1'b1, 16'd5};
    vecs[6] = '{1'b0, 16'h0000, 0, 16'h8001, 1'b1, 16'd6};

    prev_p = 16'h0;
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) do_reset();
      send_bits(vecs[v].data, vecs[v].nbits);
      if (!vecs[v].rst) check($sformatf("v%0d_hold", v), int'(p_data), int'(prev_p));
      latch($sformatf("v%0d", v));
      check($sformatf("v%0d_p_data", v), int'(p_data), int'(vecs[v].exp_p));
      check($sformatf("v%0d_frame_err", v), int'(frame_err), int'(vecs[v].exp_err));
      check($sformatf("v%0d_frame_cnt", v), int'(frame_cnt), int'(vecs[v].exp_cnt));
      prev_p = vecs[v].exp_p;
    end

    // Tied clocks: latch takes pre-shift data, so p_data lags one bit.
    do_reset();
    pv = 0;
    last_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_data = 1'b1;
      cyc(2);
      sclk = 1'b1;
      rclk = 1'b1;
      for (int k = 0; k < 8; k++) begin
        cyc(1);
        if (p_valid) begin
          pv++;
          last_err = frame_err;
        end
        if (k == 3) begin
          sclk = 1'b0;
          rclk = 1'b0;
        end
      end
      if (i == 0) begin
        check("tied_first_p_data", int'(p_data), 0);
        check("tied_first_err", int'(frame_err), 1);
      end
    end
    check("tied_pulses", pv, 16);
    check("tied_p_data", int'(p_data), 16'h7FFF);
    check("tied_last_err", int'(last_err), 1);
    check("tied_frame_cnt", int'(frame_cnt), 16);

    // Reset mid-frame with sclk held high across release.
    do_reset();
    send_bits(16'hBEEF >> 8, 8);
    s_data = 1'b1;
    sclk = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    cyc(3);
    check("mid_rst_p_data", int'(p_data), 0);
    check("mid_rst_p_valid", int'(p_valid), 0);
    check("mid_rst_frame_cnt", int'(frame_cnt), 0);
    rst_n = 1'b1;
    pv = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      if (p_valid) pv++;
    end
    sclk = 1'b0;
    cyc(4);
    check("mid_rst_no_pulse", pv, 0);
    send_bits(16'h1234, 16);
    latch("mid");
    check("mid_p_data", int'(p_data), 16'h1234);
    check("mid_frame_err", int'(frame_err), 0);
    check("mid_frame_cnt", int'(frame_cnt), 1);

    // Counter wrap from a preloaded 16'hFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    cyc(1);
    release dut.frame_cnt_q;
    cyc(1);
    check("wrap_preload", int'(frame_cnt), 16'hFFFF);
    send_bits(16'h0F0F, 16);
    latch("wrap");
    check("wrap_frame_cnt", int'(frame_cnt), 0);
    check("wrap_p_data", int'(p_data), 16'h0F0F);
    check("wrap_frame_err", int'(frame_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
